mult_sequencer: RTL and testbench

- Multi-cycle controller that sequences a 32-bit shift-add datapath to implement the MIPS mult and multu instructions.
- Produces the 64-bit product into hi/lo registers.
- Sits beside the combinational ALU. The ALU control issues start with operands; the result is read from hi/lo (mfhi/mflo) after done.
- Signed operands are converted to magnitude form, multiplied unsigned, then the product is conditionally negated.

---
 rtl/alu_pkg.sv | 16 +
 rtl/twos_negate.sv | 11 +
 rtl/mult_sequencer.sv | 135 +++++++++++++
 tb/tb_mult_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the multiply sequencer and the ALU control decode:
// state encoding, default operand width and the mult/multu selector.
package alu_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   localparam logic OP_MULTU = 1'b0;
   localparam logic OP_MULT  = 1'b1;

endpackage : alu_pkg

// File: rtl/twos_negate.sv
// Two's complement negation of an N-bit value.
module twos_negate #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   output logic [N-1:0] y
);

   assign y = ~x + {{(N-1){1'b0}}, 1'b1};

endmodule : twos_negate

// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add controller for MIPS mult/multu: operands are reduced to
// magnitudes, multiplied unsigned over WIDTH iterations, then sign-corrected into hi/lo.
module mult_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     mcand_q, mplier_q;
   logic                 neg_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 busy_q, done_q;
   logic [WIDTH-1:0]     hi_q, lo_q;

   logic [WIDTH-1:0]     a_neg_s, b_neg_s;
   logic [WIDTH-1:0]     mcand_d, mplier_d;
   logic                 neg_d;
   logic [WIDTH:0]       sum_s;
   logic [2*WIDTH-1:0]   acc_d, acc_neg_s;

   twos_negate #(.N(WIDTH)) u_neg_a (.x(a), .y(a_neg_s));
   twos_negate #(.N(WIDTH)) u_neg_b (.x(b), .y(b_neg_s));
   twos_negate #(.N(2*WIDTH)) u_neg_acc (.x(acc_q), .y(acc_neg_s));

   // Operand magnitudes and result sign, presented for capture on start.
   always_comb begin
      mcand_d  = a;
      mplier_d = b;
      neg_d    = 1'b0;
      if (is_signed == OP_MULT) begin
         neg_d = a[WIDTH-1] ^ b[WIDTH-1];
         if (a[WIDTH-1]) begin
            mcand_d = a_neg_s;
         end else begin
            mcand_d = a;
         end
         if (b[WIDTH-1]) begin
            mplier_d = b_neg_s;
         end else begin
            mplier_d = b;
         end
      end else begin
         neg_d = 1'b0;
      end
   end

   // One shift-add step: conditional add into the upper half keeping the carry.
   always_comb begin
      sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      if (mplier_q[0]) begin
         sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      end else begin
         sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end
      acc_d = {sum_s, acc_q[WIDTH-1:1]};
   end

   // Sequencer FSM with counter, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         mcand_q  <= {WIDTH{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         neg_q    <= 1'b0;
         acc_q    <= {(2*WIDTH){1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  neg_q    <= neg_d;
                  acc_q    <= {(2*WIDTH){1'b0}};
                  cnt_q    <= {CNT_W{1'b0}};
                  busy_q   <= 1'b1;
                  state_q  <= ST_CALC;
               end else begin
                  busy_q   <= 1'b0;
               end
            end
            ST_CALC: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_FIX;
               end else begin
                  state_q <= ST_CALC;
               end
            end
            ST_FIX: begin
               if (neg_q) begin
                  {hi_q, lo_q} <= acc_neg_s;
               end else begin
                  {hi_q, lo_q} <= acc_q;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule : mult_sequencer

// File: tb/tb_mult_sequencer.sv
// Directed-vector bench for mult_sequencer with hand-computed products.
module tb_mult_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec;
   int n_err;

   mult_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One complete operation: checks latency, busy duration, result and pulse width.
   task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic sg, input logic [63:0] exp);
      int edges;
      int busy_cycles;
      @(negedge clk);
      a = ta; b = tb_v; is_signed = sg; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; is_signed = ~sg;
      check({tag, " busy_rise"}, {63'd0, busy}, 64'd1);
      edges = 0;
      busy_cycles = 1;
      while (!done && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      check({tag, " latency"}, 64'(edges), 64'd33);
      check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
      check({tag, " product"}, {hi, lo}, exp);
      @(negedge clk);
      check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int edges;
      int dones;
      logic [63:0] res;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {busy, done, 62'd0}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;

      do_op("mult_7_m3",  32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op("multu_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      do_op("mult_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      do_op("mult_min2",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      do_op("mult_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
      do_op("mult_zero",  32'd0,         32'hFFFF_FFFB, 1'b1, 64'd0);
      do_op("multu_x16",  32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);

      // Start while busy must be ignored and not queued.
      @(negedge clk);
      a = 32'd3; b = 32'd5; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      dones = 0;
      res = 64'd0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         start = (cyc == 10) ? 1'b1 : 1'b0;
         a = 32'd9; b = 32'd9;
         if (done) begin
            dones++;
            res = {hi, lo};
         end
         @(posedge clk);
      end
      @(negedge clk);
      check("busy_ignore_dones", 64'(dones), 64'd1);
      check("busy_ignore_prod", res, 64'd15);
      check("busy_ignore_idle", {63'd0, busy}, 64'd0);

      // Reset in the middle of an operation discards the partial result.
      @(negedge clk);
      a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_flags", {62'd0, busy, done}, 64'd0);
      check("midrst_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;
      start = 1'b0;
      dones = 0;
      for (int cyc = 0; cyc < 45; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", 64'(dones), 64'd0);
      do_op("after_rst", 32'd2, 32'd3, 1'b0, 64'd6);

      // Back-to-back with start held high.
      @(negedge clk);
      a = 32'd4; b = 32'd4; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 32'd5; b = 32'd5;
      edges = 0;
      while (!done && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("b2b_first_lat", 64'(edges), 64'd33);
      check("b2b_first_prod", {hi, lo}, 64'd16);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b_second_busy", {63'd0, busy}, 64'd1);
      check("b2b_hold_prod", {hi, lo}, 64'd16);
      edges = 1;
      while (!done && edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("b2b_second_lat", 64'(edges), 64'd34);
      check("b2b_second_prod", {hi, lo}, 64'd25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mult_sequencer
